// File: rtl/decode_disp_imm_fetch_pkg.sv
// Shared decode definitions for the displacement/immediate extractor:
// size encodings, FSM state enum and size-legality / sign-extension helpers.
package decode_disp_imm_fetch_pkg;

  localparam int unsigned SIZE_W = 3;

  localparam logic [SIZE_W-1:0] SIZE_0 = 3'd0;
  localparam logic [SIZE_W-1:0] SIZE_1 = 3'd1;
  localparam logic [SIZE_W-1:0] SIZE_2 = 3'd2;
  localparam logic [SIZE_W-1:0] SIZE_4 = 3'd4;
  localparam logic [SIZE_W-1:0] SIZE_6 = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DISP = 2'd1,
    IMM  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Both sizes must be one of the encodings and fit the configured maxima
  function automatic logic sizes_legal(input logic [SIZE_W-1:0] disp_size,
                                       input logic [SIZE_W-1:0] imm_size,
                                       input int unsigned       disp_max,
                                       input int unsigned       imm_max,
                                       input logic              far_en);
    logic disp_ok;
    logic imm_ok;
    case (disp_size)
      SIZE_0, SIZE_1, SIZE_2, SIZE_4: disp_ok = 1'b1;
      default:                        disp_ok = 1'b0;
    endcase
    case (imm_size)
      SIZE_0, SIZE_1, SIZE_2, SIZE_4: imm_ok = 1'b1;
      SIZE_6:                         imm_ok = far_en;
      default:                        imm_ok = 1'b0;
    endcase
    return disp_ok && imm_ok &&
           (32'(disp_size) <= disp_max) && (32'(imm_size) <= imm_max);
  endfunction

  // Sign-extend a 1- or 2-byte field from its top byte; wider fields pass through
  function automatic logic [31:0] sext_field(input logic [31:0]       value,
                                             input logic [SIZE_W-1:0] size,
                                             input logic              sext_en);
    logic [31:0] result;
    result = value;
    if (sext_en) begin
      case (size)
        SIZE_1:  result = {{24{value[7]}}, value[7:0]};
        SIZE_2:  result = {{16{value[15]}}, value[15:0]};
        default: result = value;
      endcase
    end
    return result;
  endfunction

endpackage

// File: rtl/decode_disp_imm_fetch_field_accum.sv
// Generic little-endian byte accumulator: pops up to FETCH_WIDTH queue lanes
// per cycle into a N_BYTES field starting at the supplied byte offset.
module decode_field_accum #(
  parameter int unsigned N_BYTES     = 4,
  parameter int unsigned FETCH_WIDTH = 4,
  parameter int unsigned CNT_W       = $clog2(FETCH_WIDTH + 1),
  parameter int unsigned OFF_W       = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     enable,
  input  logic [OFF_W-1:0]         size,
  input  logic [OFF_W-1:0]         offset,
  input  logic [8*FETCH_WIDTH-1:0] queue_byte,
  input  logic [CNT_W-1:0]         queue_count,
  output logic [CNT_W-1:0]         take_c,
  output logic                     done_c,
  output logic [8*N_BYTES-1:0]     field_c
);

  logic [8*N_BYTES-1:0] field_q;
  int                   remaining_c;

  // Bytes taken this cycle: the smaller of what is left and what is queued
  always_comb begin
    take_c      = '0;
    done_c      = 1'b0;
    remaining_c = int'(size) - int'(offset);
    if (enable) begin
      if (remaining_c <= 0) begin
        take_c = '0;
      end else if (remaining_c < int'(queue_count)) begin
        take_c = CNT_W'(remaining_c);
      end else begin
        take_c = queue_count;
      end
      done_c = (int'(offset) + int'(take_c)) == int'(size);
    end
  end

  // Next field value: popped lane k lands at byte (offset + k)
  always_comb begin
    field_c = field_q;
    if (clear) begin
      field_c = '0;
    end else if (enable) begin
      for (int k = 0; k < int'(FETCH_WIDTH); k++) begin
        for (int j = 0; j < int'(N_BYTES); j++) begin
          if ((k < int'(take_c)) && ((int'(offset) + k) == j)) begin
            field_c[8*j +: 8] = queue_byte[8*k +: 8];
          end
        end
      end
    end
  end

  // Assembly register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      field_q <= '0;
    end else begin
      field_q <= field_c;
    end
  end

endmodule

// File: rtl/decode_disp_imm_fetch.sv
// Sequential displacement/immediate extractor between the prefetch byte queue
// and the execute-side operand latch. Fetches displacement then immediate
// bytes little-endian over as many cycles as the queue needs.
// Optional far-pointer (6-byte immediate) support: DECODE_DISP_IMM_FAR_PTR_EN.
module decode_disp_imm_fetch
  import decode_disp_imm_fetch_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH = 4,
  parameter int unsigned DISP_MAX    = 4,
  parameter int unsigned IMM_MAX     = 6
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 i_start,
  input  logic [2:0]                           i_disp_size,
  input  logic [2:0]                           i_imm_size,
  input  logic                                 i_disp_sext,
  input  logic                                 i_imm_sext,
  input  logic [8*FETCH_WIDTH-1:0]             i_queue_byte,
  input  logic [$clog2(FETCH_WIDTH+1)-1:0]     i_queue_count,
  output logic [$clog2(FETCH_WIDTH+1)-1:0]     o_queue_pop,
  output logic [31:0]                          o_displacement,
  output logic [31:0]                          o_immediate,
  output logic [15:0]                          o_selector,
  output logic [3:0]                           o_consume_bytes,
  output logic                                 o_valid,
  input  logic                                 i_accept,
  output logic                                 o_busy,
  output logic                                 o_error
);

  localparam int unsigned CNT_W = $clog2(FETCH_WIDTH + 1);

`ifdef DECODE_DISP_IMM_FAR_PTR_EN
  localparam logic        FAR_EN        = 1'b1;
  localparam int unsigned IMM_ACC_BYTES = 6;
`else
  localparam logic        FAR_EN        = 1'b0;
  localparam int unsigned IMM_ACC_BYTES = 4;
`endif

  state_e                     state_q;
  state_e                     state_d;
  logic [SIZE_W-1:0]          disp_size_q;
  logic [SIZE_W-1:0]          imm_size_q;
  logic                       disp_sext_q;
  logic                       imm_sext_q;
  logic [SIZE_W-1:0]          rcv_q;
  logic [SIZE_W-1:0]          rcv_d;

  logic                       legal_c;
  logic                       start_ok_c;
  logic                       err_c;
  logic                       disp_en_c;
  logic                       imm_en_c;
  logic                       load_out_c;

  logic [CNT_W-1:0]           disp_take_c;
  logic [CNT_W-1:0]           imm_take_c;
  logic                       disp_done_c;
  logic                       imm_done_c;
  logic [31:0]                disp_field_c;
  logic [8*IMM_ACC_BYTES-1:0] imm_field_c;

  assign legal_c    = sizes_legal(i_disp_size, i_imm_size, DISP_MAX, IMM_MAX, FAR_EN);
  assign start_ok_c = (state_q == IDLE) && i_start && legal_c;
  assign err_c      = (state_q == IDLE) && i_start && !legal_c;
  assign disp_en_c  = (state_q == DISP);
  assign imm_en_c   = (state_q == IMM);

  decode_field_accum #(
    .N_BYTES    (4),
    .FETCH_WIDTH(FETCH_WIDTH),
    .CNT_W      (CNT_W),
    .OFF_W      (SIZE_W)
  ) u_disp_accum (
    .clock      (clock),
    .reset      (reset),
    .clear      (start_ok_c),
    .enable     (disp_en_c),
    .size       (disp_size_q),
    .offset     (rcv_q),
    .queue_byte (i_queue_byte),
    .queue_count(i_queue_count),
    .take_c     (disp_take_c),
    .done_c     (disp_done_c),
    .field_c    (disp_field_c)
  );

  decode_field_accum #(
    .N_BYTES    (IMM_ACC_BYTES),
    .FETCH_WIDTH(FETCH_WIDTH),
    .CNT_W      (CNT_W),
    .OFF_W      (SIZE_W)
  ) u_imm_accum (
    .clock      (clock),
    .reset      (reset),
    .clear      (start_ok_c),
    .enable     (imm_en_c),
    .size       (imm_size_q),
    .offset     (rcv_q),
    .queue_byte (i_queue_byte),
    .queue_count(i_queue_count),
    .take_c     (imm_take_c),
    .done_c     (imm_done_c),
    .field_c    (imm_field_c)
  );

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: skip empty fields, advance the cycle after a field completes
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_ok_c) begin
          if (i_disp_size != SIZE_0) begin
            state_d = DISP;
          end else if (i_imm_size != SIZE_0) begin
            state_d = IMM;
          end else begin
            state_d = DONE;
          end
        end
      end
      DISP: begin
        if (disp_done_c) begin
          state_d = (imm_size_q != SIZE_0) ? IMM : DONE;
        end
      end
      IMM: begin
        if (imm_done_c) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (i_accept) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: queue pop, field byte counter, result load strobe
  always_comb begin
    o_queue_pop = '0;
    rcv_d       = rcv_q;
    case (state_q)
      IDLE: rcv_d = '0;
      DISP: begin
        o_queue_pop = disp_take_c;
        rcv_d       = disp_done_c ? '0 : rcv_q + SIZE_W'(disp_take_c);
      end
      IMM: begin
        o_queue_pop = imm_take_c;
        rcv_d       = imm_done_c ? '0 : rcv_q + SIZE_W'(imm_take_c);
      end
      default: rcv_d = rcv_q;
    endcase
    load_out_c = (state_d == DONE) && (state_q != DONE);
  end

  // Latched request attributes and field byte counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      disp_size_q <= '0;
      imm_size_q  <= '0;
      disp_sext_q <= 1'b0;
      imm_sext_q  <= 1'b0;
      rcv_q       <= '0;
    end else begin
      rcv_q <= rcv_d;
      if (start_ok_c) begin
        disp_size_q <= i_disp_size;
        imm_size_q  <= i_imm_size;
        disp_sext_q <= i_disp_sext;
        imm_sext_q  <= i_imm_sext;
      end
    end
  end

  // Registered results, loaded once on entry to DONE and held until accepted
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      o_displacement  <= '0;
      o_immediate     <= '0;
      o_consume_bytes <= '0;
      o_valid         <= 1'b0;
      o_busy          <= 1'b0;
      o_error         <= 1'b0;
    end else begin
      o_valid <= (state_d == DONE);
      o_busy  <= (state_d != IDLE);
      o_error <= err_c;
      if (load_out_c) begin
        o_displacement  <= sext_field(disp_field_c, disp_size_q, disp_sext_q);
        o_immediate     <= sext_field(imm_field_c[31:0], imm_size_q, imm_sext_q);
        o_consume_bytes <= (state_q == IDLE) ? 4'd0
                                             : 4'(disp_size_q) + 4'(imm_size_q);
      end
    end
  end

`ifdef DECODE_DISP_IMM_FAR_PTR_EN
  logic [15:0] selector_q;

  // Far-pointer selector: immediate bytes 4-5
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      selector_q <= '0;
    end else if (load_out_c) begin
      selector_q <= imm_field_c[47:32];
    end
  end

  assign o_selector = selector_q;
`else
  assign o_selector = 16'd0;
`endif

endmodule

// File: tb/tb_decode_disp_imm_fetch.sv
// Testbench for decode_disp_imm_fetch: directed vector table, hand-written
// starvation/backpressure/reset sequences, and randomized transactions
// checked against a byte-stream reference model.
module tb_decode_disp_imm_fetch;

  localparam int FW = 4;
  localparam int CW = $clog2(FW + 1);
`ifdef DECODE_DISP_IMM_FAR_PTR_EN
  localparam bit FAR_EN = 1'b1;
`else
  localparam bit FAR_EN = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic              i_start;
  logic [2:0]        i_disp_size;
  logic [2:0]        i_imm_size;
  logic              i_disp_sext;
  logic              i_imm_sext;
  logic [8*FW-1:0]   i_queue_byte;
  logic [CW-1:0]     i_queue_count;
  logic [CW-1:0]     o_queue_pop;
  logic [31:0]       o_displacement;
  logic [31:0]       o_immediate;
  logic [15:0]       o_selector;
  logic [3:0]        o_consume_bytes;
  logic              o_valid;
  logic              i_accept;
  logic              o_busy;
  logic              o_error;

  decode_disp_imm_fetch #(
    .FETCH_WIDTH(FW),
    .DISP_MAX   (4),
    .IMM_MAX    (6)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .i_start        (i_start),
    .i_disp_size    (i_disp_size),
    .i_imm_size     (i_imm_size),
    .i_disp_sext    (i_disp_sext),
    .i_imm_sext     (i_imm_sext),
    .i_queue_byte   (i_queue_byte),
    .i_queue_count  (i_queue_count),
    .o_queue_pop    (o_queue_pop),
    .o_displacement (o_displacement),
    .o_immediate    (o_immediate),
    .o_selector     (o_selector),
    .o_consume_bytes(o_consume_bytes),
    .o_valid        (o_valid),
    .i_accept       (i_accept),
    .o_busy         (o_busy),
    .o_error        (o_error)
  );

  always #5 clock = ~clock;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [7:0]  stream [0:15];
  int          pat [$];

  typedef struct {
    int          dsz;
    int          isz;
    bit          ds;
    bit          is_;
    logic [95:0] bytes;
    int          mode;
    logic [15:0] pat;
    int          npat;
    int          hold;
    logic [31:0] ed;
    logic [31:0] ei;
    logic [15:0] es;
    logic [3:0]  ec;
    bit          ee;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: little-endian value of n stream bytes from base (low 4 bytes)
  function automatic logic [31:0] le_val(input int base, input int n);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < n && i < 4; i++) v = v | (32'(stream[base+i]) << (8*i));
    return v;
  endfunction

  function automatic logic [31:0] model_field(input int base, input int n, input bit sx);
    logic [31:0] v;
    v = le_val(base, n);
    if (sx && (n == 1 || n == 2) && v[8*n-1]) v = v - (32'd1 << (8*n));
    return v;
  endfunction

  function automatic logic [15:0] model_sel(input int base, input int n);
    return (n == 6) ? {stream[base+5], stream[base+4]} : 16'd0;
  endfunction

  task automatic drive_lanes(input int cnt, input int ptr);
    for (int k = 0; k < FW; k++) begin
      if (k < cnt && ptr + k < 16) i_queue_byte[8*k +: 8] = stream[ptr+k];
      else                          i_queue_byte[8*k +: 8] = 8'($urandom);
    end
    i_queue_count = CW'(cnt);
  endtask

  // One transaction, entered and left at posedge+1 with the DUT idle
  task automatic do_txn(input string name, input int dsz, input int isz,
                        input bit ds, input bit is_, input int mode, input int hold,
                        input logic [31:0] ed, input logic [31:0] ei,
                        input logic [15:0] es, input logic [3:0] ec, input bit ee);
    int fsz [2];
    int ptr;
    int cnt;
    int rem;
    int zs;
    int want;
    i_start     = 1'b1;
    i_disp_size = 3'(dsz);
    i_imm_size  = 3'(isz);
    i_disp_sext = ds;
    i_imm_sext  = is_;
    i_accept    = 1'b0;
    drive_lanes($urandom_range(FW, 0), 0);
    #1 chk($sformatf("%s start_pop", name), 32'(o_queue_pop), 32'd0);
    @(posedge clock); #1;
    i_start = 1'b0;
    if (ee) begin
      chk($sformatf("%s err_pulse", name), 32'(o_error), 32'd1);
      chk($sformatf("%s err_busy", name), 32'(o_busy), 32'd0);
      @(posedge clock); #1;
      chk($sformatf("%s err_clear", name), 32'(o_error), 32'd0);
      chk($sformatf("%s err_idle", name), 32'(o_busy), 32'd0);
      return;
    end
    fsz[0] = dsz;
    fsz[1] = isz;
    ptr = 0;
    zs  = 0;
    for (int f = 0; f < 2; f++) begin
      rem = fsz[f];
      while (rem > 0) begin
        chk($sformatf("%s early_valid", name), 32'(o_valid), 32'd0);
        chk($sformatf("%s fetch_busy", name), 32'(o_busy), 32'd1);
        case (mode)
          0: cnt = FW;
          1: begin
            cnt = $urandom_range(FW, 0);
            if (zs >= 3) cnt = FW;
          end
          default: cnt = (pat.size() > 0) ? pat.pop_front() : FW;
        endcase
        zs = (cnt == 0) ? zs + 1 : 0;
        drive_lanes(cnt, ptr);
        i_start     = 1'($urandom);
        i_disp_size = 3'($urandom);
        i_imm_size  = 3'($urandom);
        i_accept    = 1'($urandom);
        want = (rem < cnt) ? rem : cnt;
        #1 chk($sformatf("%s pop", name), 32'(o_queue_pop), 32'(want));
        rem -= want;
        ptr += want;
        @(posedge clock); #1;
      end
    end
    i_start  = 1'b0;
    i_accept = 1'b0;
    chk($sformatf("%s valid", name), 32'(o_valid), 32'd1);
    chk($sformatf("%s done_busy", name), 32'(o_busy), 32'd1);
    chk($sformatf("%s disp", name), o_displacement, ed);
    chk($sformatf("%s imm", name), o_immediate, ei);
    chk($sformatf("%s sel", name), 32'(o_selector), 32'(es));
    chk($sformatf("%s consume", name), 32'(o_consume_bytes), 32'(ec));
    chk($sformatf("%s no_err", name), 32'(o_error), 32'd0);
    for (int h = 0; h < hold; h++) begin
      i_start     = 1'b1;
      i_disp_size = 3'($urandom);
      i_imm_size  = 3'($urandom);
      drive_lanes(FW, 0);
      @(posedge clock); #1;
      chk($sformatf("%s hold_valid", name), 32'(o_valid), 32'd1);
      chk($sformatf("%s hold_disp", name), o_displacement, ed);
      chk($sformatf("%s hold_imm", name), o_immediate, ei);
      chk($sformatf("%s hold_sel", name), 32'(o_selector), 32'(es));
      chk($sformatf("%s hold_err", name), 32'(o_error), 32'd0);
    end
    i_start  = 1'b0;
    i_accept = 1'b1;
    @(posedge clock); #1;
    i_accept = 1'b0;
    chk($sformatf("%s acc_valid", name), 32'(o_valid), 32'd0);
    chk($sformatf("%s acc_busy", name), 32'(o_busy), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dopt [4];
    int iopt [5];
    int dsz;
    int isz;
    bit ds;
    bit is_;
    dopt = '{0, 1, 2, 4};
    iopt = '{0, 1, 2, 4, 6};

    vt[0] = '{1, 0, 1'b1, 1'b0, 96'h80, 0, 16'h0, 0, 0,
              32'hFFFFFF80, 32'h0, 16'h0, 4'd1, 1'b0};
    vt[1] = '{4, 2, 1'b0, 1'b0, 96'hABCD_1234_5678, 2, 16'h0024, 2, 5,
              32'h12345678, 32'h0000ABCD, 16'h0, 4'd6, 1'b0};
`ifdef DECODE_DISP_IMM_FAR_PTR_EN
    vt[2] = '{0, 6, 1'b0, 1'b0, 96'h0008_1122_3344, 0, 16'h0, 0, 0,
              32'h0, 32'h11223344, 16'h0008, 4'd6, 1'b0};
`else
    vt[2] = '{0, 6, 1'b0, 1'b0, 96'h0008_1122_3344, 0, 16'h0, 0, 0,
              32'h0, 32'h0, 16'h0, 4'd0, 1'b1};
`endif
    vt[3] = '{2, 0, 1'b0, 1'b0, 96'h1234, 2, 16'h1001, 4, 0,
              32'h00001234, 32'h0, 16'h0, 4'd2, 1'b0};
    vt[4] = '{0, 0, 1'b1, 1'b1, 96'h0, 0, 16'h0, 0, 2,
              32'h0, 32'h0, 16'h0, 4'd0, 1'b0};
    vt[5] = '{2, 1, 1'b1, 1'b1, 96'h7F_FF80, 1, 16'h0, 0, 1,
              32'hFFFFFF80, 32'h0000007F, 16'h0, 4'd3, 1'b0};
    vt[6] = '{1, 4, 1'b0, 1'b1, 96'h80_0000_8080, 0, 16'h0, 0, 0,
              32'h00000080, 32'h80000080, 16'h0, 4'd5, 1'b0};
    vt[7] = '{3, 0, 1'b0, 1'b0, 96'h0, 0, 16'h0, 0, 0,
              32'h0, 32'h0, 16'h0, 4'd0, 1'b1};
    vt[8] = '{0, 5, 1'b0, 1'b0, 96'h0, 0, 16'h0, 0, 0,
              32'h0, 32'h0, 16'h0, 4'd0, 1'b1};
    vt[9] = '{4, 4, 1'b1, 1'b1, 96'hF566_7788_4433_2211, 1, 16'h0, 0, 0,
              32'h44332211, 32'hF5667788, 16'h0, 4'd8, 1'b0};

    reset         = 1'b1;
    i_start       = 1'b0;
    i_disp_size   = 3'd0;
    i_imm_size    = 3'd0;
    i_disp_sext   = 1'b0;
    i_imm_sext    = 1'b0;
    i_queue_byte  = '0;
    i_queue_count = '0;
    i_accept      = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_error", 32'(o_error), 32'd0);
    chk("rst_disp", o_displacement, 32'd0);
    chk("rst_imm", o_immediate, 32'd0);
    chk("rst_sel", 32'(o_selector), 32'd0);
    chk("rst_consume", 32'(o_consume_bytes), 32'd0);
    chk("rst_pop", 32'(o_queue_pop), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Directed vector table
    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < 16; i++) stream[i] = (i < 12) ? vt[v].bytes[8*i +: 8] : 8'h00;
      pat.delete();
      for (int p = 0; p < vt[v].npat; p++) pat.push_back(int'(vt[v].pat[4*p +: 4]));
      do_txn($sformatf("vec%0d", v), vt[v].dsz, vt[v].isz, vt[v].ds, vt[v].is_,
             vt[v].mode, vt[v].hold, vt[v].ed, vt[v].ei, vt[v].es, vt[v].ec, vt[v].ee);
    end

    // Reset in the middle of an immediate fetch
    for (int i = 0; i < 16; i++) stream[i] = 8'(8'hA0 + i);
    i_start     = 1'b1;
    i_disp_size = 3'd0;
    i_imm_size  = 3'd4;
    @(posedge clock); #1;
    i_start = 1'b0;
    drive_lanes(1, 0);
    #1 chk("mid_pop0", 32'(o_queue_pop), 32'd1);
    @(posedge clock); #1;
    drive_lanes(1, 1);
    @(posedge clock); #1;
    chk("mid_busy", 32'(o_busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    chk("mid_rst_disp", o_displacement, 32'd0);
    chk("mid_rst_imm", o_immediate, 32'd0);
    chk("mid_rst_consume", 32'(o_consume_bytes), 32'd0);
    chk("mid_rst_pop", 32'(o_queue_pop), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    for (int i = 0; i < 16; i++) stream[i] = 8'($urandom);
    do_txn("post_reset", 0, 4, 1'b0, 1'b0, 1, 0,
           model_field(0, 0, 1'b0), model_field(0, 4, 1'b0),
           model_sel(0, 4), 4'd4, 1'b0);

    // Randomized legal transactions against the byte-stream model
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 16; i++) stream[i] = 8'($urandom);
      dsz = dopt[$urandom_range(3, 0)];
      isz = iopt[$urandom_range(FAR_EN ? 4 : 3, 0)];
      ds  = 1'($urandom);
      is_ = 1'($urandom);
      pat.delete();
      do_txn($sformatf("rnd%0d", t), dsz, isz, ds, is_, 1, $urandom_range(2, 0),
             model_field(0, dsz, ds), model_field(dsz, isz, is_),
             model_sel(dsz, isz), 4'(dsz + isz), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decode_disp_imm_fetch.md
Name: decode_disp_imm_fetch

Overview:
- Sequential displacement/immediate extractor. Parametrised successor to the single-cycle combinational disp/imm decoder.
- Sits between the prefetch byte queue and the execute-side operand latch.
- Pulls displacement bytes, then immediate bytes, little-endian, across as many cycles as the queue needs to supply them.
- Supports optional sign extension, a 6-byte far-pointer immediate, and a valid/accept output handshake.

Parameters:
- FETCH_WIDTH, 4: max bytes the queue presents and the block may pop per cycle (1..8).
- DISP_MAX, 4: largest displacement size in bytes.
- IMM_MAX, 6: largest immediate size in bytes (6 = offset32 + selector16).

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- i_start  in  1  begin extraction; honoured only in IDLE
- i_disp_size  in  3  displacement size: 0, 1, 2 or 4 bytes; other values illegal
- i_imm_size  in  3  immediate size: 0, 1, 2, 4 or 6 bytes; other values illegal
- i_disp_sext  in  1  sign-extend displacement to 32 bits
- i_imm_sext  in  1  sign-extend 1- or 2-byte immediate to 32 bits
- i_queue_byte  in  8 x FETCH_WIDTH  queue head bytes; entry 0 is oldest
- i_queue_count  in  $clog2(FETCH_WIDTH+1)  number of valid head bytes
- o_queue_pop  out  $clog2(FETCH_WIDTH+1)  bytes consumed this cycle (combinational)
- o_displacement  out  32  assembled displacement
- o_immediate  out  32  assembled immediate (far pointer: offset)
- o_selector  out  16  far-pointer selector; 0 otherwise
- o_consume_bytes  out  4  disp + imm byte total of the completed extraction
- o_valid  out  1  outputs valid
- i_accept  in  1  downstream takes outputs when o_valid & i_accept
- o_busy  out  1  high in every state except IDLE
- o_error  out  1  one-cycle pulse on an illegal size

Behaviour:
- Reset: all outputs 0, FSM in IDLE, byte counters 0.
- States: IDLE, DISP, IMM, DONE.
- IDLE:
  - i_start with legal sizes: latch sizes and sext flags, clear the assembly registers.
  - Next state is DISP if disp>0, else IMM if imm>0, else DONE.
  - Illegal size: o_error=1 for one cycle, stay in IDLE, pop 0.
  - No bytes are popped in the start cycle.
- DISP/IMM:
  - pop = min(remaining bytes of current field, i_queue_count).
  - Byte i_queue_byte[k] lands at field byte offset (received + k).
  - When the field completes, the next field starts on the following cycle; leftover queue bytes are not consumed in that cycle.
  - i_queue_count=0 stalls with pop=0 and no state change.
- Far pointer (imm=6): bytes 0-3 go to o_immediate, bytes 4-5 to o_selector.
- Sign extension:
  - Applied on entry to DONE, from the top byte of the field.
  - i_imm_sext is ignored for sizes 4 and 6.
  - A 0-byte field yields 0.
- DONE:
  - o_valid=1; outputs stable while o_valid & !i_accept.
  - o_consume_bytes = disp + imm.
  - On accept go to IDLE, o_valid=0 the next cycle.
- Minimum latency start -> o_valid: 1 cycle (both sizes 0) or 1 + ceil(disp/FW) + ceil(imm/FW) cycles with a full queue.
- i_start while busy: ignored, with no effect on the current extraction.
- Reset mid-operation: immediate return to IDLE. The partial fetch is discarded; the requester re-issues it after a queue flush.
- o_queue_pop never exceeds i_queue_count and never exceeds the remaining bytes of the current field.

Optional Feature:
- Macro: DECODE_DISP_IMM_FAR_PTR_EN
- Defined: imm size 6 is legal and o_selector is driven as described above.
- Undefined: imm size 6 is illegal (o_error pulse), o_selector is tied 0, and the selector register is not built.

Decomposition:
- Shared decode package holds:
  - the size-encoding constants (SIZE_0/1/2/4/6);
  - the FSM state enum (IDLE, DISP, IMM, DONE);
  - the function computing legal-size checks.
- One sub-module, decode_field_accum: generic little-endian byte accumulator (width N bytes, FETCH_WIDTH lanes, offset in, done out).
- The top level instantiates decode_field_accum twice, once for disp and once for imm.

Test Plan:
- disp=1 (0x80, sext), imm=0, queue full -> o_displacement=0xFFFFFF80, o_consume_bytes=1, o_valid 2 cycles after start.
- disp=4 bytes 78 56 34 12, imm=2 bytes CD AB, FW=4, queue count 4 then 2 -> disp=0x12345678, imm=0x0000ABCD, pops 4,2, o_consume_bytes=6.
- Far pointer (macro on) imm=6 bytes 44 33 22 11 08 00 -> o_immediate=0x11223344, o_selector=0x0008. Macro off, same stimulus -> o_error pulse, no pop.
- Queue starvation: disp=2, count 1,0,0,1 -> pops 1,0,0,1, disp assembled correctly, no premature o_valid.
- Backpressure: i_accept=0 for 5 cycles in DONE -> outputs and o_valid held; i_start during this time ignored.
- Reset asserted mid-IMM -> all outputs 0 asynchronously, FSM in IDLE; a fresh start then completes normally.
